// File: rtl/pingpong_bridge_pkg.sv
// Shared types and width helpers for the ping-pong bridge buffer.
package pingpong_bridge_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  localparam int DEF_DEPTH      = 16;
  localparam int DEF_MAX_PASSES = 8;
  localparam int ADDR_W         = $clog2(DEF_DEPTH);
  localparam int PASS_W         = $clog2(DEF_MAX_PASSES + 1);

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int pass_w(input int max_passes);
    return $clog2(max_passes + 1);
  endfunction

endpackage

// File: rtl/pingpong_bank_mem.sv
// One bank: simple dual-port RAM, one write port, one registered read port.
// The read register only loads on re_i, so it holds the last word while the
// consumer stalls.
module pingpong_bank_mem
  import pingpong_bridge_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int W  = 256
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  // write port, contents are never reset
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  // registered read, holds when not enabled
  always_ff @(posedge clk)
    if (re_i) rdata_q <= mem_q[raddr_i];

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_bridge_buffer.sv
// Double-buffered bridge between a producer and the systolic matmul.
// Bank A/B alternate fill/drain; each filled bank is replayed num_passes times.
// Optional status outputs under `PINGPONG_BRIDGE_BUFFER_STATUS_EN.
module pingpong_bridge_buffer
  import pingpong_bridge_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int MAX_PASSES   = DEF_MAX_PASSES,
  localparam int W  = NUM_CHANNELS * DATA_WIDTH,
  localparam int AW = addr_w(DEPTH),
  localparam int PW = pass_w(MAX_PASSES),
  localparam int FW = $clog2(2 * DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic [PW-1:0] num_passes,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic          out_tile_last,
  output logic          out_bank
`ifdef PINGPONG_BRIDGE_BUFFER_STATUS_EN
  ,
  output logic          overflow_err,
  output logic          underflow_err,
  output logic [FW-1:0] fill_level
`endif
);

  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [PW-1:0] PASS_ONE = PW'(1);
  localparam logic [PW-1:0] PASS_MAX = PW'(MAX_PASSES);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  bank_state_t       st_q [2];
  bank_state_t       st_d [2];
  logic [AW:0]       len_q [2];
  logic [PW-1:0]     pass_q [2];
  logic              wsel_q, rsel_q;
  logic [AW-1:0]     widx_q, ridx_q;
  logic [PW-1:0]     pidx_q;
  logic              ov_q, ol_q, otl_q, ob_q;
  logic [1:0][W-1:0] rdata;

  logic          wr_acc, wr_close, have_word, fetch, f_last, f_tl, rel;
  logic [PW-1:0] pass_sat;

  assign in_ready  = (st_q[wsel_q] == EMPTY) || (st_q[wsel_q] == FILLING);
  assign wr_acc    = in_valid && in_ready && !flush;
  assign wr_close  = wr_acc && (in_last || widx_q == IDX_LAST);
  assign pass_sat  = (num_passes == '0) ? PASS_ONE :
                     (num_passes > PASS_MAX) ? PASS_MAX : num_passes;
  // the read-selected bank always has fetches left while FULL/DRAINING,
  // because rsel moves on as soon as its final word is fetched
  assign have_word = (st_q[rsel_q] == FULL) || (st_q[rsel_q] == DRAINING);
  assign fetch     = have_word && (!ov_q || out_ready) && !flush;
  assign f_last    = ({1'b0, ridx_q} == len_q[rsel_q] - LEN_ONE);
  assign f_tl      = f_last && (pidx_q == pass_q[rsel_q] - PASS_ONE);
  assign rel       = ov_q && out_ready && otl_q;

  // per-bank state next-state: fill, start drain, release
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      if (wr_acc && wsel_q == 1'(b))
        st_d[b] = wr_close ? FULL : FILLING;
      else if (fetch && rsel_q == 1'(b) && st_q[b] == FULL)
        st_d[b] = DRAINING;
      else if (rel && ob_q == 1'(b))
        st_d[b] = EMPTY;
      if (flush) st_d[b] = EMPTY;
    end
  end

  // bank state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
    end

  // write pointer, tile descriptors, read counters and output stage
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      len_q[0] <= '0; len_q[1] <= '0; pass_q[0] <= '0; pass_q[1] <= '0;
      wsel_q <= 1'b0; widx_q <= '0; rsel_q <= 1'b0; ridx_q <= '0; pidx_q <= '0;
      ov_q <= 1'b0; ol_q <= 1'b0; otl_q <= 1'b0; ob_q <= 1'b0;
    end else if (flush) begin
      wsel_q <= 1'b0; widx_q <= '0; rsel_q <= 1'b0; ridx_q <= '0; pidx_q <= '0;
      ov_q <= 1'b0; ol_q <= 1'b0; otl_q <= 1'b0; ob_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (wr_close) begin
          len_q[wsel_q]  <= {1'b0, widx_q} + LEN_ONE;
          pass_q[wsel_q] <= pass_sat;
          wsel_q         <= ~wsel_q;
          widx_q         <= '0;
        end else begin
          widx_q <= widx_q + 1'b1;
        end
      end
      if (fetch) begin
        ov_q  <= 1'b1;
        ol_q  <= f_last;
        otl_q <= f_tl;
        ob_q  <= rsel_q;
        if (f_last) begin
          ridx_q <= '0;
          if (f_tl) begin
            pidx_q <= '0;
            rsel_q <= ~rsel_q;
          end else begin
            pidx_q <= pidx_q + 1'b1;
          end
        end else begin
          ridx_q <= ridx_q + 1'b1;
        end
      end else if (out_ready) begin
        ov_q <= 1'b0;
      end
    end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_bank_mem #(.AW(AW), .W(W)) u_mem (
      .clk     (clk),
      .we_i    (wr_acc && wsel_q == 1'(b)),
      .waddr_i (widx_q),
      .wdata_i (in_data),
      .re_i    (fetch && rsel_q == 1'(b)),
      .raddr_i (ridx_q),
      .rdata_o (rdata[b])
    );
  end

  assign out_valid     = ov_q;
  assign out_data      = ov_q ? rdata[ob_q] : '0;
  assign out_last      = ov_q && ol_q;
  assign out_tile_last = ov_q && otl_q;
  assign out_bank      = ov_q && ob_q;

`ifdef PINGPONG_BRIDGE_BUFFER_STATUS_EN
  logic ovf_q, unf_q;
  logic any_drain;
  logic [FW-1:0] held [2];

  assign any_drain = (st_q[0] == DRAINING) || (st_q[1] == DRAINING);

  // sticky protocol-violation flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (in_valid && !in_ready) ovf_q <= 1'b1;
      if (out_ready && !ov_q && any_drain) unf_q <= 1'b1;
    end

  // words held per bank; a FILLING bank is always the write-selected one
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      held[b] = '0;
      if (st_q[b] == FILLING) held[b] = FW'(widx_q);
      else if (st_q[b] == FULL || st_q[b] == DRAINING) held[b] = FW'(len_q[b]);
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
  assign fill_level    = held[0] + held[1];
`endif

endmodule

// File: doc/pingpong_bridge_buffer.md
Name: pingpong_bridge_buffer

Overview:
Parametrised successor to the single-bank bridge buffer. Double-buffered (bank A/B) multi-channel storage between a producer stage and the systolic matmul. One bank fills while the other drains. Each filled bank can be replayed a programmable number of passes, so one operand tile feeds several output-column sweeps without being reloaded. Valid/ready handshakes on both sides replace the fixed-timing enable/address control.

Parameters:
NUM_CHANNELS, 4, parallel buffer instances sharing control
DATA_WIDTH, 64, bits per channel per word
DEPTH, 16, words per bank (power of two, >=2)
MAX_PASSES, 8, maximum replay passes per bank

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of both banks and the output stage
in_valid  in  1  write word valid
in_ready  out  1  write side can accept
in_data  in  NUM_CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
in_last  in  1  closes the current bank early (short tile)
num_passes  in  $clog2(MAX_PASSES+1)  replay count, sampled with the closing word
out_valid  out  1  read word valid
out_ready  in  1  consumer accepts
out_data  out  NUM_CHANNELS*DATA_WIDTH  read word, same channel packing
out_last  out  1  last word of the current pass
out_tile_last  out  1  last word of the final pass; bank released on this beat
out_bank  out  1  bank being drained (0=A, 1=B)

Behaviour:
- Reset/flush: all outputs 0 except in_ready=1; both banks EMPTY; write pointer selects A; read pointer selects A.
- Per-bank FSM: EMPTY -> FILLING on first accepted write; FILLING -> FULL on accepted write with in_last=1 or on write index DEPTH-1.
  - On that closing write, latch len = index+1 and passes = num_passes. num_passes=0 is treated as 1; values >MAX_PASSES saturate to MAX_PASSES.
  - FULL -> DRAINING when the read side selects the bank.
  - DRAINING -> EMPTY on the handshake of the out_tile_last beat.
- Write side:
  - in_ready = write-selected bank is EMPTY or FILLING.
  - Write accepted when in_valid && in_ready.
  - On close, the write pointer toggles to the other bank.
  - in_ready stays 0 while both banks are FULL or DRAINING.
- Read side:
  - Drains banks in fill order.
  - Word index r runs 0..len-1; pass counter p runs 0..passes-1.
  - out_last = (r==len-1); out_tile_last = out_last && (p==passes-1).
- Latency:
  - First out_valid appears 2 cycles after the closing write (1 cycle state update, 1 cycle registered memory read).
  - Throughput is 1 word/cycle while out_ready=1, including across pass boundaries and bank switches when the next bank is already FULL (no bubble).
- Output stage:
  - Registered. out_data/out_last/out_tile_last/out_bank hold stable while out_valid && !out_ready.
  - out_valid deasserts only after a handshake.
- Simultaneous events:
  - A write closing bank X in the same cycle the read side releases bank Y is legal; both take effect.
  - A write to a bank in the same cycle it is released is impossible by construction (a released bank is only writable from the next cycle).
- len=1: out_last=1 on every beat; with passes=1, out_tile_last=1 on the single beat.
- flush or rst mid-operation:
  - Discards all data.
  - Next cycle out_valid=0 and in_ready=1.
  - A write presented in the same cycle as flush is dropped.
- Memory: one dual-port array per bank, DEPTH x NUM_CHANNELS*DATA_WIDTH, one write port and one read port, no reset on contents.

Optional Feature:
PINGPONG_BRIDGE_BUFFER_STATUS_EN: adds outputs overflow_err (1, sticky), underflow_err (1, sticky) and fill_level ($clog2(2*DEPTH+1), words currently held in FILLING+FULL+DRAINING banks).
- overflow_err sets on in_valid while in_ready=0 and flush is low.
- underflow_err sets on out_ready while out_valid=0 and a bank is DRAINING.
- Both clear only on rst/flush.
- Without the macro: ports absent, no counters synthesised, core behaviour identical.

Decomposition:
- Package pingpong_bridge_pkg holds:
  - typedef enum bank_state_t {EMPTY, FILLING, FULL, DRAINING}
  - localparam helpers ADDR_W=$clog2(DEPTH) and PASS_W=$clog2(MAX_PASSES+1)
- Sub-module pingpong_bank_mem: one bank's simple dual-port RAM with registered read, instantiated twice.

Test Plan:
- DEPTH=16, write 16 words (channel c word k = {c,k}), num_passes=1 -> 16 output beats in order; out_last and out_tile_last only on beat 15; first out_valid 2 cycles after the closing write.
- Write tile A (16 words, passes=3), then tile B immediately -> 48 beats of A with out_last every 16th, then B with no bubble; in_ready=0 only while A is DRAINING and B is FULL.
- Write 5 words with in_last on the 5th, num_passes=0 -> 5 beats; out_tile_last on beat 4 (passes treated as 1).
- Hold out_ready=0 for 10 cycles with out_valid=1 -> out_data and flags stable; releasing resumes with no lost or duplicated word.
- Assert flush while A is DRAINING (beat 7) and B is FILLING -> next cycle out_valid=0, in_ready=1; next tile starts in bank A from index 0.
- With PINGPONG_BRIDGE_BUFFER_STATUS_EN: fill both banks, drive in_valid while in_ready=0 -> overflow_err=1 and fill_level=32; after flush both read 0.
